// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, full/empty and
// threshold flags, and registered rejected-request error pulses.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output;
// without it, read data is registered with one cycle of latency.
module sync_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rd_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     wr_error_o,
  output logic                     rd_error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_ok;
  logic             wr_ok;

  // Flags decode straight from the registered occupancy count.
  assign full_o         = (count == FULL_CNT);
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= AF_CNT);
  assign almost_empty_o = (count <= AE_CNT);
  assign count_o        = count;

  // A read needs data; a write needs space, or a same-cycle read that frees a slot.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  // Pointer and occupancy bookkeeping; reset discards every stored entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  // Rejected requests raise a one-cycle error pulse on the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_error_o <= 1'b0;
      rd_error_o <= 1'b0;
    end else begin
      wr_error_o <= wr_en_i && !wr_ok;
      rd_error_o <= rd_en_i && !rd_ok;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_ok && !rst_i) mem[wr_ptr] <= wdata_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented combinationally whenever the FIFO holds data.
  assign rdata_o    = empty_o ? '0 : mem[rd_ptr];
  assign rd_valid_o = !empty_o;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rd_valid_q;

  // Head entry is captured at the accepting edge and held until the next read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) rdata_q <= mem[rd_ptr];
    end
  end

  assign rdata_o    = rdata_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param (WIDTH=8, DEPTH=16,
// AFULL_THRESH=14, AEMPTY_THRESH=2). Follows SYNC_FIFO_FWFT_EN when defined.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [4:0] count;
  logic       wr_err;
  logic       rd_err;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata), .rd_valid_o(rd_valid),
    .full_o(full), .empty_o(empty), .almost_full_o(afull),
    .almost_empty_o(aempty), .count_o(count),
    .wr_error_o(wr_err), .rd_error_o(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill 16 words base, base+1, ... with count/flag checks after each write.
  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wdata = base + 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(afull), 32'((i + 1) >= 14));
      chk("fill_full",  32'(full),  32'((i + 1) == 16));
    end
    wr_en = 1'b0;
  endtask

  // Issue one read (rd_en left high) and check the word in the mode's timing.
  task automatic read_word(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"},  32'(rdata),    32'(exp));
    step();
`else
    step();
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"},  32'(rdata),    32'(exp));
`endif
  endtask

  task automatic drain(input string tag, input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      read_word(tag, base + 8'(i));
      chk({tag, "_count"}, 32'(count), 32'(15 - i));
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_empty"},  32'(empty),    32'd1);
    chk({tag, "_rvalid"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
    step();
    step();
    // Reset state
    chk("rst_count",  32'(count),    32'd0);
    chk("rst_empty",  32'(empty),    32'd1);
    chk("rst_aempty", 32'(aempty),   32'd1);
    chk("rst_full",   32'(full),     32'd0);
    chk("rst_afull",  32'(afull),    32'd0);
    chk("rst_rvalid", 32'(rd_valid), 32'd0);
    chk("rst_wrerr",  32'(wr_err),   32'd0);
    chk("rst_rderr",  32'(rd_err),   32'd0);
    chk("rst_rdata",  32'(rdata),    32'd0);
    rst = 1'b0;
    step();

    // Fill and drain in order; first-word visibility differs per mode
    fill(8'h01);
    chk("aempty_full", 32'(aempty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("first_vis_valid", 32'(rd_valid), 32'd1);
    chk("first_vis_data",  32'(rdata),    32'h01);
`else
    chk("first_vis_valid", 32'(rd_valid), 32'd0);
`endif
    drain("rd1", 8'h01);
    chk("aempty_end", 32'(aempty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rdata_hold", 32'(rdata), 32'h10);
`endif

    // Overflow attempt at full
    fill(8'h21);
    wr_en = 1'b1; wdata = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("ovf_err",   32'(wr_err), 32'd1);
    chk("ovf_count", 32'(count),  32'd16);
    step();
    chk("ovf_err_off", 32'(wr_err), 32'd0);
    chk("ovf_count2",  32'(count),  32'd16);
    drain("rd2", 8'h21);

    // Underflow attempt at empty
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_err",    32'(rd_err),   32'd1);
    chk("unf_count",  32'(count),    32'd0);
    chk("unf_rvalid", 32'(rd_valid), 32'd0);
    step();
    chk("unf_err_off", 32'(rd_err),   32'd0);
    chk("unf_rvalid2", 32'(rd_valid), 32'd0);

    // Empty with simultaneous write and read: write taken, read rejected
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h55;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("emp_both_rderr", 32'(rd_err), 32'd1);
    chk("emp_both_wrerr", 32'(wr_err), 32'd0);
    chk("emp_both_count", 32'(count),  32'd1);
    read_word("emp_both_rd", 8'h55);
    rd_en = 1'b0;
    step();
    chk("emp_both_empty", 32'(empty), 32'd1);

    // Full with simultaneous write and read over two pointer wraps
    fill(8'h01);
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      wdata = 8'h11 + 8'(i);
      read_word("stream", 8'h01 + 8'(i));
      chk("stream_count", 32'(count),  32'd16);
      chk("stream_wrerr", 32'(wr_err), 32'd0);
      chk("stream_rderr", 32'(rd_err), 32'd0);
    end
    wr_en = 1'b0;
    drain("rd3", 8'h21);

    // Asynchronous reset mid-cycle discards stored words
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wdata = 8'h61 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
    step();
    chk("rst_req_count", 32'(count),  32'd0);
    chk("rst_req_wrerr", 32'(wr_err), 32'd0);
    chk("rst_req_rderr", 32'(rd_err), 32'd0);
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b0;
    step();
    wr_en = 1'b1; wdata = 8'h77;
    step();
    wr_en = 1'b0;
    chk("post_rst_count", 32'(count), 32'd1);
    read_word("post_rst_rd", 8'h77);
    rd_en = 1'b0;
    step();
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, count at or above which almost_full_o asserts (1..DEPTH-1).
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, count at or below which almost_empty_o asserts (1..DEPTH-1).
REQ-005 SHALL provide port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_i  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-007 SHALL provide port wr_en_i  input  1  write request.
REQ-008 SHALL provide port wdata_i  input  WIDTH  write data.
REQ-009 SHALL provide port rd_en_i  input  1  read request.
REQ-010 SHALL provide port rdata_o  output  WIDTH  read data.
REQ-011 SHALL provide port rd_valid_o  output  1  rdata_o holds valid data.
REQ-012 SHALL provide port full_o / empty_o  output  1 each  occupancy flags.
REQ-013 SHALL provide port almost_full_o / almost_empty_o  output  1 each  threshold flags.
REQ-014 SHALL provide port count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL provide port wr_error_o / rd_error_o  output  1 each  rejected-request pulses.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH; write/read pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-017 Write accepted when wr_en_i=1 and (full_o=0, or rd_en_i=1 and the read is accepted); wdata_i stored at write pointer at that edge.
REQ-018 Read accepted when rd_en_i=1 and empty_o=0.
REQ-019 count_o SHALL update at the same edge: +1 write only, -1 read only, unchanged both or neither.
REQ-020 full_o = (count_o==DEPTH), empty_o = (count_o==0), almost_full_o = (count_o>=AFULL_THRESH), almost_empty_o = (count_o<=AEMPTY_THRESH); all combinational from registered count.
REQ-021 Full and wr_en_i=rd_en_i=1: both accepted, count stays DEPTH, no error.
REQ-022 Empty and wr_en_i=rd_en_i=1: write accepted, read rejected, rd_error_o pulses.
REQ-023 Rejected write SHALL leave memory and pointers unchanged and assert wr_error_o for exactly the following cycle (registered); likewise rd_error_o for a rejected read.
REQ-024 rdata_o SHALL hold its last value when no read is accepted.
REQ-025 Data SHALL emerge in strict write order across pointer wrap.

Reset
REQ-026 rst_i=1 SHALL immediately clear pointers and count; empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, count_o=0, rd_valid_o=0, wr_error_o=0, rd_error_o=0, rdata_o=0.
REQ-027 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared; requests during reset are ignored and raise no error.

Configuration
REQ-028 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-029 Without SYNC_FIFO_FWFT_EN: rdata_o registered, loaded with the head entry at the edge a read is accepted; rd_valid_o pulses for the cycle after each accepted read (1-cycle latency).
REQ-030 With SYNC_FIFO_FWFT_EN: rdata_o = head entry combinationally whenever empty_o=0; rd_valid_o = !empty_o; an accepted read advances to the next entry at that edge (0-cycle latency); rdata_o is don't-care when empty.

Verification (WIDTH=8, DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2)
REQ-031 Write 16 words 0x01..0x10 -> count_o 16, full_o=1, almost_full_o=1 from count 14; read 16 -> data 0x01..0x10 in order, empty_o=1.
REQ-032 At full, one extra write 0xAA -> wr_error_o high exactly one cycle, count_o stays 16, 0xAA never read back.
REQ-033 At empty, rd_en_i for one cycle -> rd_error_o high exactly one cycle, count_o 0, rd_valid_o stays 0.
REQ-034 Fill to 16, then 32 cycles simultaneous wr/rd with incrementing data -> no errors, count_o constant 16, output order preserved across two pointer wraps.
REQ-035 Write 5 words, assert rst_i mid-cycle -> count_o=0, empty_o=1 immediately without waiting for clock; next write/read returns the new word, not old data.
REQ-036 Run REQ-031 with and without SYNC_FIFO_FWFT_EN -> first word 0x01 visible on rdata_o with rd_valid_o=1 before any rd_en_i (FWFT) vs one cycle after first accepted read (default).
